// File: rtl/uart_pkg.sv
// Types and defaults shared by the UART receive and transmit buffers.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AFULL = 12;

  typedef struct packed {
    logic                   ferr;
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and host-side signals of the UART receive buffer.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [UART_DATA_W-1:0] in_data;
  logic                   in_parity_err;
  logic                   in_frame_err;
  logic                   out_valid;
  logic                   out_ready;
  logic [UART_DATA_W-1:0] out_data;
  logic                   out_perr;
  logic                   out_ferr;
  logic [ADDR_W:0]        count;
  logic                   almost_full;
  logic                   overflow;
  logic                   perr_seen;
  logic                   ferr_seen;
  logic                   clr_status;

  modport slave (
    input  in_valid, in_data, in_parity_err, in_frame_err, out_ready, clr_status,
    output in_ready, out_valid, out_data, out_perr, out_ferr, count, almost_full,
           overflow, perr_seen, ferr_seen
  );

  modport master (
    output in_valid, in_data, in_parity_err, in_frame_err, out_ready, clr_status,
    input  in_ready, out_valid, out_data, out_perr, out_ferr, count, almost_full,
           overflow, perr_seen, ferr_seen
  );
endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read. Contents are not reset.
module uart_fifo_ram #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: in-order byte FIFO with per-entry error tags and sticky status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = UART_FIFO_AFULL
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);
  localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AFULL = (ADDR_W+1)'(AFULL_LVL);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic              wr_en, rd_en;
  logic              perr_q, ferr_q, perr_rise, ferr_rise;
  logic              perr_pend, ferr_pend;
  logic              overflow_q, perr_seen_q, ferr_seen_q, afull_q;
  rx_entry_t         wr_entry, rd_entry;

  // Full blocks writes even when a read happens in the same cycle.
  assign bus.in_ready  = (count_q != CNT_FULL);
  assign bus.out_valid = (count_q != '0);
  assign wr_en         = bus.in_valid && bus.in_ready;
  assign rd_en         = bus.out_valid && bus.out_ready;

  // Receiver error outputs are sticky levels; only their rising edges mean a new error.
  assign perr_rise = bus.in_parity_err && !perr_q;
  assign ferr_rise = bus.in_frame_err  && !ferr_q;

  always_comb begin
    wr_entry      = '0;
    wr_entry.ferr = ferr_pend || ferr_rise;
    wr_entry.perr = perr_pend || perr_rise;
    wr_entry.data = bus.in_data;
  end

  always_comb begin
    count_nxt = count_q;
    if (wr_en && !rd_en)      count_nxt = count_q + 1'b1;
    else if (rd_en && !wr_en) count_nxt = count_q - 1'b1;
  end

  uart_fifo_ram #(
    .WIDTH  ($bits(rx_entry_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      afull_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      afull_q <= (count_nxt >= CNT_AFULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_pend <= 1'b0;
      ferr_pend <= 1'b0;
    end else begin
      perr_q <= bus.in_parity_err;
      ferr_q <= bus.in_frame_err;
      // An edge in a write cycle goes straight into that entry's tag.
      if (wr_en)          perr_pend <= 1'b0;
      else if (perr_rise) perr_pend <= 1'b1;
      if (wr_en)          ferr_pend <= 1'b0;
      else if (ferr_rise) ferr_pend <= 1'b1;
    end
  end

  // Set events take priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      perr_seen_q <= 1'b0;
      ferr_seen_q <= 1'b0;
    end else begin
      if (bus.in_valid && !bus.in_ready) overflow_q <= 1'b1;
      else if (bus.clr_status)           overflow_q <= 1'b0;
      if (perr_rise)                     perr_seen_q <= 1'b1;
      else if (bus.clr_status)           perr_seen_q <= 1'b0;
      if (ferr_rise)                     ferr_seen_q <= 1'b1;
      else if (bus.clr_status)           ferr_seen_q <= 1'b0;
    end
  end

  assign bus.out_data    = rd_entry.data;
  assign bus.out_perr    = rd_entry.perr;
  assign bus.out_ferr    = rd_entry.ferr;
  assign bus.count       = count_q;
  assign bus.almost_full = afull_q;
  assign bus.overflow    = overflow_q;
  assign bus.perr_seen   = perr_seen_q;
  assign bus.ferr_seen   = ferr_seen_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic clk;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] d;

  uart_rx_fifo_if #(.ADDR_W(4)) bus();

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_LVL(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] v, input logic p, input logic f);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  32'(bus.out_data), 32'(v));
    check({tag, "_perr"},  32'(bus.out_perr), 32'(p));
    check({tag, "_ferr"},  32'(bus.out_ferr), 32'(f));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_parity_err = 1'b0;
    bus.in_frame_err = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("rst_iready", 32'(bus.in_ready), 32'd1);
    check("rst_afull", 32'(bus.almost_full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_seen", 32'({bus.perr_seen, bus.ferr_seen}), 32'd0);
    reset = 1'b0;
    tick();

    // Three bytes, one-cycle latency, then ordered drain
    bus.in_valid = 1'b1;
    bus.in_data = 8'h41;
    tick();
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_data", 32'(bus.out_data), 32'h41);
    bus.in_data = 8'h42;
    tick();
    bus.in_data = 8'h43;
    tick();
    bus.in_valid = 1'b0;
    check("abc_count", 32'(bus.count), 32'd3);
    tick();
    check("abc_hold", 32'(bus.out_data), 32'h41);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abc_order", 32'(bus.out_data), 32'(8'h41 + i));
      tick();
    end
    bus.out_ready = 1'b0;
    check("abc_empty", 32'(bus.out_valid), 32'd0);

    // Fill to full, overflow, clear, drain
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h80 + i));
      if (i == 10) check("af_11", 32'(bus.almost_full), 32'd0);
      if (i == 11) check("af_12", 32'(bus.almost_full), 32'd1);
    end
    check("full_count", 32'(bus.count), 32'd16);
    check("full_iready", 32'(bus.in_ready), 32'd0);
    check("full_ovf0", 32'(bus.overflow), 32'd0);
    push(8'h99);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    bus.clr_status = 1'b1;
    push(8'h99);
    check("ovf_setwins", 32'(bus.overflow), 32'd1);
    tick();
    bus.clr_status = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pop("drain", 8'(8'h80 + i), 1'b0, 1'b0);
      if (i == 0) check("rd_iready", 32'(bus.in_ready), 32'd1);
      if (i == 4) check("af_11_dn", 32'(bus.almost_full), 32'd0);
    end
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    check("no_99", 32'(bus.count), 32'd0);

    // Parity edge two cycles ahead of the write
    bus.in_parity_err = 1'b1;
    tick();
    check("perr_seen", 32'(bus.perr_seen), 32'd1);
    tick();
    push(8'h55);
    push(8'h56);
    bus.in_parity_err = 1'b0;
    pop("p55", 8'h55, 1'b1, 1'b0);
    pop("p56", 8'h56, 1'b0, 1'b0);

    // Frame edge coincident with the write
    bus.in_frame_err = 1'b1;
    push(8'h7E);
    check("ferr_seen", 32'(bus.ferr_seen), 32'd1);
    push(8'h7F);
    pop("f7e", 8'h7E, 1'b0, 1'b1);
    pop("f7f", 8'h7F, 1'b0, 1'b0);
    bus.in_frame_err = 1'b0;
    tick();
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    check("seen_clr", 32'({bus.perr_seen, bus.ferr_seen}), 32'd0);

    // Steady state at count 8 with simultaneous read and write
    for (int i = 0; i < 8; i++) begin
      d = 8'(8'h10 + i);
      push(d);
      exp_q.push_back(d);
    end
    check("c8_count", 32'(bus.count), 32'd8);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 8'(8'h20 + i);
      bus.in_data = d;
      check("c8_data", 32'(bus.out_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      exp_q.push_back(d);
      tick();
      check("c8_hold", 32'(bus.count), 32'd8);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      pop("c8_drain", d, 1'b0, 1'b0);
    end
    check("c8_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with data in flight
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    check("pre_rst", 32'(bus.count), 32'd5);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_ovalid", 32'(bus.out_valid), 32'd0);
    check("arst_iready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("post_iready", 32'(bus.in_ready), 32'd1);
    push(8'h01);
    check("post_valid", 32'(bus.out_valid), 32'd1);
    check("post_data", 32'(bus.out_data), 32'h01);
    check("post_count", 32'(bus.count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
